seq_alu_mdu: RTL and testbench
==============================

Name: seq_alu_mdu

Overview:
Parametrised successor to the 2-bit-control combinational ALU (AND/OR/ADD/SUB/Zero).
- Widens the opcode to 4 bits, adds logic, compare and shift ops, and a signed overflow flag.
- Adds an iterative multiply/divide unit writing HI/LO registers, with a valid/ready handshake.
- Sits in the execute stage of the MIPS datapath. The pipeline stalls on in_ready low.

Parameters:
WIDTH, 32, operand/result width (≥8, power of two)
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  unit can accept; equals (state==IDLE)
alu_ctrl  in  4  opcode
op_a  in  WIDTH  operand 1
op_b  in  WIDTH  operand 2
result  out  WIDTH  registered result; held until next completion
zero  out  1  result==0, registered with result
overflow  out  1  signed overflow (ADD/SUB only, else 0)
dbz  out  1  divide-by-zero flag for last DIV/DIVU, else 0
illegal  out  1  last accepted opcode was reserved
out_valid  out  1  one-cycle completion pulse
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
Reset:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- rst_n low clears immediately: state=IDLE, result=0, zero/overflow/dbz/illegal/out_valid=0, hi=lo=0.
- Inputs are ignored while rst_n is low.

Accept and hold:
- Accept occurs when in_valid && in_ready at a rising edge (edge k).
- result, zero and the flags change only on completion.

Opcodes (codes 0000–0011 match the legacy 2-bit encoding):
- 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 NOR.
- 0110 SLT (signed), 0111 SLTU; compare result is 0 or 1 zero-extended.
- 1000 SLL, 1001 SRL, 1010 SRA: shift op_a by op_b[SHW-1:0].
- 1011 MULT, 1100 MULTU, 1101 DIV, 1110 DIVU.
- 1111 reserved.

Single-cycle ops (0000–1010, 1111):
- Result is registered at edge k; out_valid is high for the cycle following edge k.
- in_ready stays 1, so back-to-back accepts are allowed every cycle.
- 1111: result=0, illegal=1.
- ADD/SUB wrap modulo 2^WIDTH; overflow is set on signed overflow.

Multiply/divide FSM (IDLE -> MUL or DIV -> IDLE):
- At accept: operands are latched, signs recorded and magnitudes taken (signed ops only), iteration counter loaded with WIDTH.
- in_ready=0 from edge k until completion.
- MUL: shift-add, one bit per cycle. After WIDTH iterations, {hi,lo} = 2·WIDTH product. For MULT, the product is negated if the operand signs differ.
- DIV: restoring, one quotient bit per cycle. lo=quotient, hi=remainder. Signed: quotient truncates toward zero; remainder takes the dividend's sign.
- Completion at edge k+WIDTH: hi/lo/result written (result=lo, zero=(lo==0)), out_valid pulses during the following cycle, state returns to IDLE, in_ready=1 in that same cycle.
- Most-negative ÷ -1 (DIV): lo=100…0, hi=0, no trap.

Divide by zero (op_b==0, DIV/DIVU):
- No iteration; completes at edge k+1.
- lo=all ones, hi=op_a, result=lo, dbz=1.

Other rules:
- Single-cycle ops never modify hi/lo.
- MUL/DIV clear overflow and illegal; dbz is cleared by any non-divide completion.
- rst_n low mid-iteration aborts the operation: no out_valid, hi/lo=0, and in_ready=1 while rst_n is low.
- in_valid while in_ready=0 is ignored; the requester must hold it.

Test Plan:
1. Legacy ops, op_a=0x00000055, op_b=0x000040AA:
   - AND -> 0x00000000, zero=1.
   - OR -> 0x000040FF.
   - ADD -> 0x000040FF.
   - SUB -> 0xFFFFBFAB, zero=0.
   - Each op gives out_valid one cycle after accept; issue back-to-back with in_ready held 1.
2. Flags:
   - ADD 0x7FFFFFFF+0x00000001 -> 0x80000000, overflow=1.
   - SUB 0x55-0x55 -> 0, zero=1.
   - SLT 0xFFFFFFFF,1 -> 1; SLTU same operands -> 0.
   - SRA 0x80000000 by 4 -> 0xF8000000.
   - Opcode 1111 -> result 0, illegal=1.
3. Multiply:
   - MULT -3×7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; out_valid exactly 32 cycles after accept; in_ready=0 throughout.
   - MULTU 0xFFFFFFFF×0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
4. Divide:
   - DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU 100/7 -> lo=14, hi=2.
   - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
   - DIV 5/0 -> one-cycle latency, lo=0xFFFFFFFF, hi=5, dbz=1.
5. Reset mid-MULT (rst_n low 10 cycles after accept):
   - hi=lo=0, no out_valid, in_ready=1 after release.
   - A subsequent ADD 2+3 returns 5.
6. Stall and hold:
   - ADD with AND/OR ops presented while DIVU is busy -> ignored.
   - hi/lo remain unchanged by a following ADD.

Source files
------------

// File: rtl/seq_alu_mdu.sv
// seq_alu_mdu: execute-stage ALU with an iterative multiply/divide unit.
//   Single-cycle ops (logic, add/sub, compare, shift) complete one edge after
//   accept. MULT/MULTU/DIV/DIVU run one bit per cycle and write HI/LO.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready = unit idle)
//   alu_ctrl, op_a, op_b  opcode and operands
//   result, zero          registered result and result==0
//   overflow, dbz, illegal  status flags of the last completion
//   out_valid             one-cycle completion pulse
//   hi, lo                multiply/divide result registers
//
// state | meaning
// IDLE  | accepting requests, single-cycle ops complete here
// MUL   | shift-add multiply iterations
// DIV   | restoring divide iterations (or one-cycle divide-by-zero)
module seq_alu_mdu #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             dbz,
    output logic             illegal,
    output logic             out_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;

    localparam logic [3:0] OP_MULT  = 4'b1011;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIV   = 4'b1101;
    localparam logic [3:0] OP_DIVU  = 4'b1110;

    localparam logic [SHW:0] CNT_INIT = (SHW+1)'(WIDTH);

    logic [1:0]       state;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             neg_q, neg_r, dbz_pend;

    assign in_ready = (state == IDLE);

    // ---------------- single-cycle ALU ----------------
    logic [WIDTH-1:0] sum, diff, alu_res;
    logic [SHW-1:0]   shamt;
    logic             alu_ovf, alu_ill;

    assign sum   = op_a + op_b;
    assign diff  = op_a - op_b;
    assign shamt = op_b[SHW-1:0];

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (alu_ctrl)
            4'b0000: alu_res = op_a & op_b;
            4'b0001: alu_res = op_a | op_b;
            4'b0010: begin
                alu_res = sum;
                alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'b0011: begin
                alu_res = diff;
                alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'b0100: alu_res = op_a ^ op_b;
            4'b0101: alu_res = ~(op_a | op_b);
            4'b0110: alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            4'b1000: alu_res = op_a << shamt;
            4'b1001: alu_res = op_a >> shamt;
            4'b1010: alu_res = $signed(op_a) >>> shamt;
            4'b1111: alu_ill = 1'b1;
            default: alu_res = '0;
        endcase
    end

    // ---------------- mul/div setup ----------------
    logic             is_mdu, is_div, is_signed, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign is_mdu    = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_MULTU) ||
                       (alu_ctrl == OP_DIV)  || (alu_ctrl == OP_DIVU);
    assign is_div    = (alu_ctrl == OP_DIV) || (alu_ctrl == OP_DIVU);
    assign is_signed = (alu_ctrl == OP_MULT) || (alu_ctrl == OP_DIV);
    assign sa        = is_signed & op_a[WIDTH-1];
    assign sb        = is_signed & op_b[WIDTH-1];
    assign mag_a     = sa ? -op_a : op_a;
    assign mag_b     = sb ? -op_b : op_b;

    // ---------------- iteration datapath ----------------
    // Multiply: {acc_hi, acc_lo} is the product register; multiplier bits
    // shift out of acc_lo[0] as the partial sum shifts in from the top.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
    logic [2*WIDTH-1:0] mul_prod, mul_fin;

    assign mul_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};
    assign mul_prod = {mul_hi_n, mul_lo_n};
    assign mul_fin  = neg_q ? -mul_prod : mul_prod;

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits
    // out of the top and quotient bits in at the bottom.
    logic [WIDTH:0]   div_sh, div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_n, div_lo_n, div_q, div_r;

    assign div_sh   = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, opnd};
    assign div_sub  = div_sh - {1'b0, opnd};
    assign div_hi_n = div_ge ? div_sub[WIDTH-1:0] : div_sh[WIDTH-1:0];
    assign div_lo_n = {acc_lo[WIDTH-2:0], div_ge};
    assign div_q    = neg_q ? -div_lo_n : div_lo_n;
    assign div_r    = neg_r ? -div_hi_n : div_hi_n;

    logic             done;
    logic [WIDTH-1:0] fin_hi, fin_lo;

    always_comb begin
        done   = 1'b0;
        fin_hi = '0;
        fin_lo = '0;
        if (state == MUL) begin
            done   = (cnt == 1);
            fin_hi = mul_fin[2*WIDTH-1:WIDTH];
            fin_lo = mul_fin[WIDTH-1:0];
        end else if (state == DIV) begin
            done = dbz_pend || (cnt == 1);
            if (dbz_pend) begin
                fin_hi = acc_hi;
                fin_lo = '1;
            end else begin
                fin_hi = div_r;
                fin_lo = div_q;
            end
        end
    end

    // ---------------- sequential ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dbz_pend  <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            dbz       <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_mdu) begin
                            state    <= is_div ? DIV : MUL;
                            cnt      <= CNT_INIT;
                            neg_q    <= sa ^ sb;
                            neg_r    <= sa;
                            opnd     <= mag_b;
                            dbz_pend <= is_div && (op_b == '0);
                            // divide-by-zero returns the raw dividend in HI
                            acc_hi   <= (is_div && (op_b == '0)) ? op_a : '0;
                            acc_lo   <= mag_a;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            overflow  <= alu_ovf;
                            illegal   <= alu_ill;
                            dbz       <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi_n;
                    acc_lo <= mul_lo_n;
                    cnt    <= cnt - 1'b1;
                end
                DIV: begin
                    acc_hi <= div_hi_n;
                    acc_lo <= div_lo_n;
                    cnt    <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase

            if (done) begin
                state     <= IDLE;
                hi        <= fin_hi;
                lo        <= fin_lo;
                result    <= fin_lo;
                zero      <= (fin_lo == '0);
                overflow  <= 1'b0;
                illegal   <= 1'b0;
                dbz       <= (state == DIV) && dbz_pend;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu_mdu.sv
module tb_seq_alu_mdu;

    localparam logic [3:0] AND_ = 4'b0000, OR_ = 4'b0001, ADD = 4'b0010, SUB = 4'b0011;
    localparam logic [3:0] XOR_ = 4'b0100, NOR_ = 4'b0101, SLT = 4'b0110, SLTU = 4'b0111;
    localparam logic [3:0] SLL = 4'b1000, SRL = 4'b1001, SRA = 4'b1010;
    localparam logic [3:0] MULT = 4'b1011, MULTU = 4'b1100, DIV = 4'b1101, DIVU = 4'b1110;
    localparam logic [3:0] RSVD = 4'b1111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_ctrl = '0;
    logic [31:0] op_a = '0, op_b = '0;
    logic [31:0] result, hi, lo;
    logic        zero, overflow, dbz, illegal, out_valid;

    seq_alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .op_a(op_a), .op_b(op_b), .result(result),
        .zero(zero), .overflow(overflow), .dbz(dbz), .illegal(illegal),
        .out_valid(out_valid), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic        z, ov, dz, il;
        logic [31:0] hi, lo;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_hi = '0, m_lo = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input int id, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s (op %0d): got=%h expected=%h", tag, id, got, exp);
        end
    endtask

    task automatic push(input int id, input logic [31:0] res, input logic ov, input logic dz, input logic il);
        exp_t e;
        e.id = id; e.res = res; e.z = (res == 32'd0); e.ov = ov; e.dz = dz; e.il = il;
        e.hi = m_hi; e.lo = m_lo;
        q.push_back(e);
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        chk("in_ready_at_issue", 0, {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; alu_ctrl = op; op_a = a; op_b = b;
    endtask

    // Called at a negedge j cycles after the accept edge; waits for out_valid.
    task automatic wait_done(input int j0, input int lat, input int id);
        int j = j0;
        in_valid = 1'b0;
        while (!out_valid && j < 200) begin
            chk("in_ready_busy", id, {63'd0, in_ready}, 64'd0);
            @(negedge clk);
            j++;
        end
        chk("latency", id, 64'(j), 64'(lat));
        chk("ready_on_done", id, {63'd0, in_ready}, 64'd1);
    endtask

    // Scoreboard: every out_valid pops and compares one expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            chk("expected_out_valid", -1, 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                chk("result",   e.id, 64'(result),   64'(e.res));
                chk("zero",     e.id, 64'(zero),     64'(e.z));
                chk("overflow", e.id, 64'(overflow), 64'(e.ov));
                chk("dbz",      e.id, 64'(dbz),      64'(e.dz));
                chk("illegal",  e.id, 64'(illegal),  64'(e.il));
                chk("hi",       e.id, 64'(hi),       64'(e.hi));
                chk("lo",       e.id, 64'(lo),       64'(e.lo));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        // reset state
        #3;
        chk("rst_result", 0, 64'(result), 64'd0);
        chk("rst_flags", 0, 64'({zero, overflow, dbz, illegal, out_valid}), 64'd0);
        chk("rst_hilo", 0, {hi, lo}, 64'd0);
        chk("rst_ready", 0, 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // legacy and extended single-cycle ops, back-to-back
        drive(AND_, 32'h55, 32'h40AA);        push(1, 32'h0, 0, 0, 0);
        drive(OR_,  32'h55, 32'h40AA);        push(2, 32'h40FF, 0, 0, 0);
        drive(ADD,  32'h55, 32'h40AA);        push(3, 32'h40FF, 0, 0, 0);
        drive(SUB,  32'h55, 32'h40AA);        push(4, 32'hFFFFBFAB, 0, 0, 0);
        drive(XOR_, 32'h55, 32'h40AA);        push(5, 32'h40FF, 0, 0, 0);
        drive(NOR_, 32'h55, 32'h40AA);        push(6, 32'hFFFFBF00, 0, 0, 0);
        drive(ADD,  32'h7FFFFFFF, 32'h1);     push(7, 32'h80000000, 1, 0, 0);
        drive(SUB,  32'h80000000, 32'h1);     push(8, 32'h7FFFFFFF, 1, 0, 0);
        drive(SUB,  32'h55, 32'h55);          push(9, 32'h0, 0, 0, 0);
        drive(SLT,  32'hFFFFFFFF, 32'h1);     push(10, 32'h1, 0, 0, 0);
        drive(SLTU, 32'hFFFFFFFF, 32'h1);     push(11, 32'h0, 0, 0, 0);
        drive(SRA,  32'h80000000, 32'h4);     push(12, 32'hF8000000, 0, 0, 0);
        drive(SRL,  32'h80000000, 32'd31);    push(13, 32'h1, 0, 0, 0);
        drive(SLL,  32'h55, 32'h24);          push(14, 32'h550, 0, 0, 0);
        drive(RSVD, 32'h1234, 32'h5678);      push(15, 32'h0, 0, 0, 1);
        drive(ADD,  32'h1, 32'h1);            push(16, 32'h2, 0, 0, 0);
        @(negedge clk); in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("queue_drained_alu", 0, 64'(q.size()), 64'd0);

        // multiply
        drive(MULT, 32'hFFFFFFFD, 32'd7);
        m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFEB; push(20, m_lo, 0, 0, 0);
        @(negedge clk); wait_done(0, 32, 20);
        drive(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        m_hi = 32'hFFFFFFFE; m_lo = 32'h00000001; push(21, m_lo, 0, 0, 0);
        @(negedge clk); wait_done(0, 32, 21);

        // divide
        drive(DIV, 32'hFFFFFFF9, 32'd2);
        m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFD; push(22, m_lo, 0, 0, 0);
        @(negedge clk); wait_done(0, 32, 22);
        drive(DIVU, 32'd100, 32'd7);
        m_hi = 32'd2; m_lo = 32'd14; push(23, m_lo, 0, 0, 0);
        @(negedge clk); wait_done(0, 32, 23);
        drive(DIV, 32'h80000000, 32'hFFFFFFFF);
        m_hi = 32'h0; m_lo = 32'h80000000; push(24, m_lo, 0, 0, 0);
        @(negedge clk); wait_done(0, 32, 24);
        drive(DIV, 32'd5, 32'd0);
        m_hi = 32'd5; m_lo = 32'hFFFFFFFF; push(25, m_lo, 0, 1, 0);
        @(negedge clk); wait_done(0, 1, 25);
        drive(ADD, 32'd10, 32'd20);           push(26, 32'd30, 0, 0, 0);
        @(negedge clk); in_valid = 1'b0;

        // reset in the middle of a multiply
        drive(MULT, 32'd1234, 32'd5678);
        @(negedge clk); in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_hi = '0; m_lo = '0;
        chk("abort_hilo", 30, {hi, lo}, 64'd0);
        chk("abort_ready", 30, 64'(in_ready), 64'd1);
        chk("abort_out_valid", 30, 64'(out_valid), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("abort_no_completion", 30, 64'(seen), 64'd0);
        drive(ADD, 32'd2, 32'd3);             push(31, 32'd5, 0, 0, 0);
        @(negedge clk); in_valid = 1'b0;

        // requests presented while busy are ignored
        drive(DIVU, 32'd1000, 32'd10);
        m_hi = 32'd0; m_lo = 32'd100; push(40, m_lo, 0, 0, 0);
        @(negedge clk);
        alu_ctrl = ADD; op_a = 32'd1; op_b = 32'd1;
        for (int j = 0; j < 5; j++) begin
            chk("stall_ready", 40, 64'(in_ready), 64'd0);
            @(negedge clk);
            if (j == 2) begin alu_ctrl = AND_; op_a = 32'hF; op_b = 32'h3; end
            if (j == 3) alu_ctrl = OR_;
        end
        wait_done(5, 32, 40);
        drive(ADD, 32'd7, 32'd8);             push(41, 32'd15, 0, 0, 0);
        @(negedge clk); in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("hilo_kept", 41, {hi, lo}, {32'd0, 32'd100});
        chk("queue_drained_end", 0, 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
